// File: rtl/nanotrade_order_rx.sv
// -----------------------------------------------------------------------------
// nanotrade_order_rx
//
// Order receive front end for the nanotrade matching engine. Bytes arriving on
// in_byte/in_valid are assembled into order frames (limit: 3 bytes, market:
// 2 bytes, cancel: 1 byte), validated, and queued in a small show-ahead FIFO.
// The FIFO head is offered to the matching engine on an ord_valid/ord_ready
// handshake. Malformed, stalled and dropped frames raise a one-cycle error
// strobe with a sticky code and a saturating error counter.
//
// Header byte: [7] marker (must be 1), [6:5] type, [4] side, [3:0] id.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   design enable; low holds the parser idle (FIFO keeps running)
//   in_byte    in   [7:0] received byte
//   in_valid   in   one-cycle strobe per byte, synchronous to clk
//   ord_valid  out  FIFO head holds an order
//   ord_ready  in   matching engine takes the head this cycle
//   ord_type   out  [1:0] 00 limit, 01 market, 10 cancel
//   ord_side   out  0 buy, 1 sell
//   ord_id     out  [3:0] order id
//   ord_price  out  [7:0] price (0 for market/cancel)
//   ord_qty    out  [7:0] quantity (0 for cancel)
//   fifo_count out  [3:0] occupied FIFO entries
//   err_pulse  out  one-cycle error strobe
//   err_code   out  [1:0] 0 bad header, 1 zero qty, 2 timeout, 3 overflow (sticky)
//   drop_cnt   out  [7:0] saturating error count
// -----------------------------------------------------------------------------
module nanotrade_order_rx #(
  parameter int FIFO_DEPTH  = 4,    // power of two, 2..8
  parameter int TIMEOUT_CYC = 255   // 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       ord_valid,
  input  logic       ord_ready,
  output logic [1:0] ord_type,
  output logic       ord_side,
  output logic [3:0] ord_id,
  output logic [7:0] ord_price,
  output logic [7:0] ord_qty,
  output logic [3:0] fifo_count,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt
);

  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DEPTH_C = 4'(FIFO_DEPTH);
  // Last timer value before the abort fires: the abort happens on the
  // TIMEOUT_CYC-th consecutive cycle without a byte.
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYC - 1);

  localparam logic [1:0]  T_LIMIT  = 2'b00;
  localparam logic [1:0]  T_MARKET = 2'b01;
  localparam logic [1:0]  T_CANCEL = 2'b10;

  localparam logic [1:0]  E_HDR  = 2'd0;
  localparam logic [1:0]  E_QTY  = 2'd1;
  localparam logic [1:0]  E_TOUT = 2'd2;
  localparam logic [1:0]  E_OVF  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRICE  = 2'd1,
    S_QTY    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  // FIFO entry layout: {type, side, id, price, qty}
  typedef struct packed {
    logic [1:0] typ;
    logic       side;
    logic [3:0] id;
    logic [7:0] price;
    logic [7:0] qty;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Parser state
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_timer;

  logic [1:0] r_f_type;
  logic       r_f_side;
  logic [3:0] r_f_id;
  logic [7:0] r_f_price;
  logic [7:0] r_f_qty;

  logic       w_cap_hdr;
  logic       w_cap_price;
  logic       w_cap_qty;
  logic       w_timer_clr;
  logic       w_timer_inc;
  logic       w_commit;
  logic       w_perr;
  logic [1:0] w_perr_code;

  logic [1:0] w_hdr_type;
  logic       w_hdr_ok;
  logic       w_timeout;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  entry_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [3:0]         r_count;

  logic               w_pop;
  logic               w_push_ok;
  logic               w_push;
  logic               w_ovf;
  entry_t             w_wr_entry;
  entry_t             w_head;

  // ---------------------------------------------------------------------------
  // Error reporting
  // ---------------------------------------------------------------------------
  logic               r_err_pulse;
  logic [1:0]         r_err_code;
  logic [7:0]         r_drop_cnt;
  logic               w_err;
  logic [1:0]         w_err_code;

  assign w_hdr_type = in_byte[6:5];
  assign w_hdr_ok   = in_byte[7] && (in_byte[6:5] != 2'b11);
  assign w_timeout  = (r_timer == TO_LAST);

  // ---------------------------------------------------------------------------
  // Parser FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Parser FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cap_hdr   = 1'b0;
    w_cap_price = 1'b0;
    w_cap_qty   = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_inc = 1'b0;
    w_commit    = 1'b0;
    w_perr      = 1'b0;
    w_perr_code = E_HDR;

    if (!ena) begin
      // Disabled: abandon any partial frame silently.
      w_state_nxt = S_IDLE;
      w_timer_clr = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_timer_clr = 1'b1;
          if (in_valid) begin
            if (!w_hdr_ok) begin
              w_perr      = 1'b1;
              w_perr_code = E_HDR;
            end else begin
              w_cap_hdr = 1'b1;
              case (w_hdr_type)
                T_CANCEL: w_state_nxt = S_COMMIT;
                T_MARKET: w_state_nxt = S_QTY;
                default:  w_state_nxt = S_PRICE;
              endcase
            end
          end
        end

        S_PRICE: begin
          // Price is opaque data: any value, including bit7 set, is taken.
          if (in_valid) begin
            w_cap_price = 1'b1;
            w_timer_clr = 1'b1;
            w_state_nxt = S_QTY;
          end else if (w_timeout) begin
            w_perr      = 1'b1;
            w_perr_code = E_TOUT;
            w_timer_clr = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_timer_inc = 1'b1;
          end
        end

        S_QTY: begin
          if (in_valid) begin
            w_timer_clr = 1'b1;
            if (in_byte == 8'd0) begin
              w_perr      = 1'b1;
              w_perr_code = E_QTY;
              w_state_nxt = S_IDLE;
            end else begin
              w_cap_qty   = 1'b1;
              w_state_nxt = S_COMMIT;
            end
          end else if (w_timeout) begin
            w_perr      = 1'b1;
            w_perr_code = E_TOUT;
            w_timer_clr = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_timer_inc = 1'b1;
          end
        end

        S_COMMIT: begin
          // in_valid is not looked at here; upstream leaves a gap cycle.
          w_commit    = 1'b1;
          w_timer_clr = 1'b1;
          w_state_nxt = S_IDLE;
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_timer_clr = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Inter-byte timer and frame capture registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= 8'd0;
    end else if (w_timer_clr) begin
      r_timer <= 8'd0;
    end else if (w_timer_inc) begin
      r_timer <= r_timer + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_type  <= 2'd0;
      r_f_side  <= 1'b0;
      r_f_id    <= 4'd0;
      r_f_price <= 8'd0;
      r_f_qty   <= 8'd0;
    end else begin
      if (w_cap_hdr) begin
        // Fields a frame type does not carry stay zero.
        r_f_type  <= w_hdr_type;
        r_f_side  <= in_byte[4];
        r_f_id    <= in_byte[3:0];
        r_f_price <= 8'd0;
        r_f_qty   <= 8'd0;
      end
      if (w_cap_price) begin
        r_f_price <= in_byte;
      end
      if (w_cap_qty) begin
        r_f_qty <= in_byte;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Order FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  assign w_pop      = (r_count != 4'd0) && ord_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok  = (r_count < DEPTH_C) || w_pop;
  assign w_push     = w_commit && w_push_ok;
  assign w_ovf      = w_commit && !w_push_ok;
  assign w_wr_entry = '{typ: r_f_type, side: r_f_side, id: r_f_id,
                        price: r_f_price, qty: r_f_qty};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign ord_valid  = (r_count != 4'd0);
  assign fifo_count = r_count;

  // Stale memory contents never leak out while the FIFO is empty.
  assign ord_type  = ord_valid ? w_head.typ   : 2'd0;
  assign ord_side  = ord_valid ? w_head.side  : 1'b0;
  assign ord_id    = ord_valid ? w_head.id    : 4'd0;
  assign ord_price = ord_valid ? w_head.price : 8'd0;
  assign ord_qty   = ord_valid ? w_head.qty   : 8'd0;

  // ---------------------------------------------------------------------------
  // Error strobe, sticky code and saturating drop counter
  // ---------------------------------------------------------------------------
  // Parser errors and overflow are mutually exclusive: overflow only arises
  // in COMMIT, where the parser raises nothing.
  assign w_err      = w_perr || w_ovf;
  assign w_err_code = w_ovf ? E_OVF : w_perr_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse <= 1'b0;
      r_err_code  <= 2'd0;
      r_drop_cnt  <= 8'd0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_nanotrade_order_rx.sv
// -----------------------------------------------------------------------------
// Bench for nanotrade_order_rx. Frames are generated at the frame level; the
// expected order stream and error stream are queued when a frame is sent, and
// a monitor on the falling edge pops and compares whatever the DUT presents.
// FIFO acceptance is decided from the modelled queue occupancy at the commit
// cycle together with the ready level seen in that cycle.
// -----------------------------------------------------------------------------
module tb_nanotrade_order_rx;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       ord_valid;
  logic       ord_ready;
  logic [1:0] ord_type;
  logic       ord_side;
  logic [3:0] ord_id;
  logic [7:0] ord_price;
  logic [7:0] ord_qty;
  logic [3:0] fifo_count;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  nanotrade_order_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .ord_valid  (ord_valid),
    .ord_ready  (ord_ready),
    .ord_type   (ord_type),
    .ord_side   (ord_side),
    .ord_id     (ord_id),
    .ord_price  (ord_price),
    .ord_qty    (ord_qty),
    .fifo_count (fifo_count),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .drop_cnt   (drop_cnt)
  );

  typedef struct packed {
    logic [1:0] t;
    logic       s;
    logic [3:0] id;
    logic [7:0] p;
    logic [7:0] q;
  } ord_t;

  ord_t       exp_q[$];
  logic [1:0] err_q[$];
  int         exp_drop;
  logic [1:0] exp_code;
  bit         commit_in;
  bit         arm;
  ord_t       commit_ord;
  ord_t       arm_ord;
  bit         rdy_rand;
  int         n_tests = 0;
  int         n_fail  = 0;

  int         m_sz;
  bit         m_acc;
  logic [1:0] m_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      m_sz = exp_q.size();
      check("fifo_count", 32'(fifo_count), 32'(m_sz));
      check("ord_valid", 32'(ord_valid), 32'(m_sz != 0));
      if (m_sz != 0)
        check("head", 32'({ord_type, ord_side, ord_id, ord_price, ord_qty}), 32'(exp_q[0]));
      else
        check("empty_outputs", 32'({ord_type, ord_side, ord_id, ord_price, ord_qty}), 32'd0);

      if (err_pulse) begin
        if (err_q.size() == 0) begin
          check("err_unexpected", 32'd1, 32'd0);
        end else begin
          m_c = err_q.pop_front();
          exp_code = m_c;
          if (exp_drop < 255) exp_drop++;
        end
      end
      check("err_code", 32'(err_code), 32'(exp_code));
      check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));

      m_acc = 1'b0;
      if (arm) begin
        m_acc = (m_sz < DEPTH) || (m_sz > 0 && ord_ready);
        if (!m_acc) err_q.push_back(2'd3);
      end
      if (m_sz > 0 && ord_ready) void'(exp_q.pop_front());
      if (arm && m_acc) exp_q.push_back(arm_ord);
      arm       = commit_in;
      arm_ord   = commit_ord;
      commit_in = 1'b0;
    end
  end

  // Random consumer
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) ord_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [7:0] b, input bit last, input ord_t o);
    in_byte  = b;
    in_valid = 1'b1;
    if (last) begin
      commit_ord = o;
      commit_in  = 1'b1;
    end
    cyc(1);
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [1:0] t, input logic s, input logic [3:0] id,
                            input logic [7:0] p, input logic [7:0] q, input int unsigned gmax);
    ord_t       o;
    logic [7:0] hdr;
    hdr = {1'b1, t, s, id};
    o   = {t, s, id, (t == 2'd0) ? p : 8'd0, (t == 2'd2) ? 8'd0 : q};
    if (t == 2'd2) begin
      put(hdr, 1'b1, o);
    end else begin
      put(hdr, 1'b0, o);
      cyc($urandom_range(0, gmax));
      if (t == 2'd0) begin
        put(p, 1'b0, o);
        cyc($urandom_range(0, gmax));
      end
      if (q == 8'd0) begin
        err_q.push_back(2'd1);
        put(q, 1'b0, o);
      end else begin
        put(q, 1'b1, o);
      end
    end
    cyc(1 + $urandom_range(0, gmax));
  endtask

  task automatic bad_hdr(input logic [7:0] b);
    err_q.push_back(2'd0);
    put(b, 1'b0, '0);
    cyc(1 + $urandom_range(0, 1));
  endtask

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    b = 8'($urandom);
    if (b[0]) b[7] = 1'b0;
    else begin
      b[7]   = 1'b1;
      b[6:5] = 2'b11;
    end
    return b;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    err_q.delete();
    exp_drop  = 0;
    exp_code  = 2'd0;
    arm       = 1'b0;
    commit_in = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    ena       = 1'b1;
    in_byte   = 8'd0;
    in_valid  = 1'b0;
    ord_ready = 1'b0;
    rdy_rand  = 1'b0;
    clear_model();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ord_valid", 32'(ord_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_err", 32'({err_pulse, err_code, drop_cnt}), 32'd0);
    check("rst_ord_fields", 32'({ord_type, ord_side, ord_id, ord_price, ord_qty}), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Limit frame latency: valid appears two cycles after the last byte
    put(8'h85, 1'b0, '0);
    put(8'h64, 1'b0, '0);
    put(8'h0A, 1'b1, {2'b00, 1'b0, 4'd5, 8'd100, 8'd10});
    check("lat_commit_cycle", 32'(ord_valid), 32'd0);
    cyc(1);
    check("lat_valid", 32'(ord_valid), 32'd1);
    check("limit_fields", 32'({ord_type, ord_side, ord_id, ord_price, ord_qty}),
          32'({2'b00, 1'b0, 4'd5, 8'd100, 8'd10}));
    check("limit_count", 32'(fifo_count), 32'd1);
    cyc(2);
    ord_ready = 1'b1;
    cyc(1);
    ord_ready = 1'b0;
    cyc(1);

    // Market then cancel, popped in order
    put(8'hB3, 1'b0, '0);
    put(8'h07, 1'b1, {2'b01, 1'b1, 4'd3, 8'd0, 8'd7});
    cyc(1);
    put(8'hC9, 1'b1, {2'b10, 1'b0, 4'd9, 8'd0, 8'd0});
    cyc(2);
    check("mc_count", 32'(fifo_count), 32'd2);
    ord_ready = 1'b1;
    check("mc_first", 32'({ord_type, ord_side, ord_id, ord_qty}), 32'({2'b01, 1'b1, 4'd3, 8'd7}));
    cyc(1);
    check("mc_second", 32'({ord_type, ord_side, ord_id, ord_qty}), 32'({2'b10, 1'b0, 4'd9, 8'd0}));
    cyc(1);
    ord_ready = 1'b0;
    check("mc_drained", 32'(ord_valid), 32'd0);
    cyc(1);

    // Error codes
    bad_hdr(8'h12);
    check("bad_marker", 32'({err_code, drop_cnt}), 32'({2'd0, 8'd1}));
    bad_hdr(8'hE0);
    check("bad_type", 32'({err_code, drop_cnt}), 32'({2'd0, 8'd2}));
    send_frame(2'd0, 1'b0, 4'd1, 8'd50, 8'd0, 0);
    check("zero_qty", 32'({err_code, drop_cnt, fifo_count}), 32'({2'd1, 8'd3, 4'd0}));

    // Timeout in PRICE, then in QTY
    err_q.push_back(2'd2);
    put(8'h81, 1'b0, '0);
    cyc(TO + 2);
    check("timeout_price", 32'({err_code, drop_cnt}), 32'({2'd2, 8'd4}));
    send_frame(2'd0, 1'b1, 4'd2, 8'd33, 8'd44, 1);
    err_q.push_back(2'd2);
    put(8'hA2, 1'b0, '0);
    cyc(TO + 2);
    check("timeout_qty", 32'({err_code, drop_cnt}), 32'({2'd2, 8'd5}));
    // Gaps one short of the timeout are tolerated
    put(8'h86, 1'b0, '0);
    cyc(TO - 1);
    put(8'hF0, 1'b0, '0);
    cyc(TO - 1);
    put(8'h11, 1'b1, {2'b00, 1'b0, 4'd6, 8'hF0, 8'h11});
    cyc(2);
    check("gap_below_timeout", 32'({err_code, drop_cnt}), 32'({2'd2, 8'd5}));
    ord_ready = 1'b1;
    cyc(4);
    ord_ready = 1'b0;

    // ena low aborts a partial frame silently and ignores bytes
    put(8'h85, 1'b0, '0);
    ena = 1'b0;
    cyc(1);
    put(8'h12, 1'b0, '0);
    cyc(1);
    ena = 1'b1;
    cyc(1);
    send_frame(2'd0, 1'b1, 4'd7, 8'd200, 8'd9, 1);
    check("ena_no_error", 32'(drop_cnt), 32'd5);

    // Overflow, then push coinciding with a pop
    for (int i = 0; i < 5; i++) send_frame(2'd0, 1'b0, 4'(i), 8'(10 + i), 8'(1 + i), 1);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_code", 32'(err_code), 32'd3);
    put(8'h8E, 1'b0, '0);
    put(8'h55, 1'b0, '0);
    put(8'h66, 1'b1, {2'b00, 1'b0, 4'd14, 8'h55, 8'h66});
    ord_ready = 1'b1;
    cyc(1);
    ord_ready = 1'b0;
    cyc(2);
    check("push_with_pop_count", 32'(fifo_count), 32'd4);
    ord_ready = 1'b1;
    cyc(6);
    ord_ready = 1'b0;

    // drop_cnt saturates at 255
    repeat (260) bad_hdr(rand_bad());
    cyc(2);
    check("drop_saturate", 32'(drop_cnt), 32'd255);

    // Randomised traffic with a random consumer
    rdy_rand = 1'b1;
    repeat (200) begin
      case ($urandom_range(0, 7))
        0, 1:    send_frame(2'd0, 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 3);
        2, 3:    send_frame(2'd1, 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 3);
        4, 5:    send_frame(2'd2, 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 3);
        6:       bad_hdr(rand_bad());
        default: send_frame(2'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), 8'($urandom), 8'd0, 3);
      endcase
    end
    rdy_rand  = 1'b0;
    cyc(1);
    ord_ready = 1'b1;
    cyc(6);
    ord_ready = 1'b0;

    // Asynchronous reset mid-frame with a full FIFO
    for (int i = 0; i < 4; i++) send_frame(2'd2, 1'b1, 4'(i), 8'd0, 8'd0, 0);
    put(8'h85, 1'b0, '0);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    check("mid_rst_valid", 32'(ord_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_drop", 32'({err_code, drop_cnt}), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    check("post_rst_idle", 32'(ord_valid), 32'd0);
    send_frame(2'd0, 1'b1, 4'd12, 8'd77, 8'd88, 0);
    cyc(1);
    check("post_rst_frame", 32'({fifo_count, ord_type, ord_side, ord_id, ord_price, ord_qty}),
          32'({4'd1, 2'b00, 1'b1, 4'd12, 8'd77, 8'd88}));

    // Drain and make sure nothing is outstanding
    ord_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
    ord_ready = 1'b0;
    cyc(2);
    check("final_orders_left", 32'(exp_q.size()), 32'd0);
    check("final_errors_left", 32'(err_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nanotrade_order_rx.md
Name: nanotrade_order_rx

Overview:
Front-end stage of tt_um_nanotrade. It sits directly upstream of the matching engine.
- Parses the byte stream arriving on the dedicated inputs into order frames (limit, market, cancel).
- Validates each frame and buffers complete orders in a small show-ahead FIFO.
- Presents orders to the matching engine over a valid/ready handshake.
- Reports malformed, stalled or dropped frames.

Parameters:
FIFO_DEPTH, 4, order buffer entries (power of two, 2..8)
TIMEOUT_CYC, 255, max clk cycles between bytes of one frame before abort (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
ena  in  1  design enable; low = parser held idle
in_byte  in  8  input byte (ui_in)
in_valid  in  1  one-cycle strobe per byte, already synchronised to clk
ord_valid  out  1  FIFO head holds an order
ord_ready  in  1  matching engine accepts head this cycle
ord_type  out  2  00 limit, 01 market, 10 cancel
ord_side  out  1  0 buy, 1 sell
ord_id  out  4  order id
ord_price  out  8  price (0 for market/cancel)
ord_qty  out  8  quantity (0 for cancel)
fifo_count  out  4  occupied entries
err_pulse  out  1  one-cycle error strobe
err_code  out  2  0 bad header, 1 zero qty, 2 timeout, 3 overflow; held until next error
drop_cnt  out  8  saturating count of errors

Behaviour:
- Reset (async on rst_n low):
  - FSM to IDLE; FIFO emptied.
  - ord_valid=0, all ord_* outputs=0, fifo_count=0.
  - err_pulse=0, err_code=0, drop_cnt=0, timer=0.
- Header byte layout: bit7 = marker (must be 1), bits6:5 = type, bit4 = side, bits3:0 = id.
- FSM states: IDLE, PRICE, QTY, COMMIT. Transitions on in_valid:
  - IDLE, marker=0 or type=11: error code 0, stay IDLE.
  - IDLE, type=10 (cancel): capture side/id, go to COMMIT. Cancel is a 1-byte frame.
  - IDLE, type=01 (market): capture header, price:=0, go to QTY. Market is a 2-byte frame.
  - IDLE, type=00 (limit): capture header, go to PRICE. Limit is a 3-byte frame.
  - PRICE: capture price, go to QTY. Any value is legal, including bit7=1; no resync on mid-frame bytes.
  - QTY: capture qty. qty==0 gives error code 1 and returns to IDLE; otherwise go to COMMIT.
  - COMMIT: one cycle. Push the frame to the FIFO, return to IDLE. in_valid is ignored in COMMIT; upstream guarantees a gap of at least 1 cycle after the last byte of a frame.
- Timeout:
  - In PRICE/QTY the timer counts cycles without in_valid; it is reset on every accepted byte.
  - Timer reaching TIMEOUT_CYC gives error code 2 and returns to IDLE; the partial frame is discarded.
- Push/pop rules:
  - Push is accepted iff count<FIFO_DEPTH, or a pop occurs in the same cycle.
  - Otherwise error code 3; the frame is dropped and FIFO contents are unchanged.
  - Pop occurs when ord_valid && ord_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: last byte accepted in cycle N; COMMIT in cycle N+1; ord_valid high from cycle N+2 if the FIFO was empty. The head is stable while ord_valid && !ord_ready.
- FIFO output: show-ahead. ord_* reflect the head entry and are driven to 0 when the FIFO is empty.
- Errors:
  - err_pulse is high for exactly one cycle per error.
  - err_code is updated in the same cycle and then held.
  - drop_cnt increments per error and saturates at 255.
  - Only one error can occur per cycle.
- ena low:
  - Parser is forced to IDLE without error and the timer is cleared.
  - in_valid is ignored.
  - FIFO output and handshake keep operating.
- Reset mid-frame or mid-handshake: everything is cleared immediately; nothing is presented after release until a new frame completes.

Test Plan:
- Limit frame: bytes 0x85, 0x64, 0x0A, ord_ready=0 -> ord_valid rises 2 cycles after the last byte; type=00, side=0, id=5, price=100, qty=10; fifo_count=1.
- Market then cancel: bytes 0xB3, 0x07, then 0xC9 -> two entries. First: type=01, side=1, id=3, price=0, qty=7. Second: type=10, side=0, id=9, qty=0. Raising ord_ready pops one entry per cycle in order.
- Errors:
  - Byte 0x12 -> err_pulse, err_code=0, drop_cnt=1.
  - Byte 0xE0 (type=11) -> err_code=0, drop_cnt=2.
  - Limit frame with qty 0x00 -> err_code=1, drop_cnt=3, no push.
- Timeout: header 0x81, then no byte for TIMEOUT_CYC cycles -> err_code=2, FSM back in IDLE. A following valid frame is parsed correctly.
- Overflow: 5 limit frames with ord_ready=0 (FIFO_DEPTH=4) -> fifo_count=4, 5th gives err_code=3. A 6th frame whose COMMIT coincides with ord_ready=1 is accepted and fifo_count stays 4.
- Reset: assert rst_n low mid-frame with a full FIFO -> ord_valid=0, fifo_count=0, drop_cnt=0 immediately (asynchronously). After release, a fresh frame parses normally.
